// File: rtl/sync_fifo_rd_ctrl_if.sv
// Bundle of push/pop and read-side status signals for sync_fifo_rd_ctrl.
// master = producer/consumer side, slave = FIFO controller side.
interface sync_fifo_rd_ctrl_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 4
);
  // Handshake: write_enable/read_enable are requests sampled on each rising edge; a
  // request is taken only when the matching status allows it (push: !wrfull, or a
  // same-edge pop; pop: !rdempty). Rejected requests leave no trace except underflow.
  logic                     write_enable;
  logic [DATA_WIDTH-1:0]    write_data;
  logic                     read_enable;
  logic [ADDRESS_WIDTH-1:0] aempty_value;
  logic                     underflow_clr;
  logic [DATA_WIDTH-1:0]    read_data;
  logic                     rdempty;
  logic                     wrfull;
  logic                     rd_almost_empty;
  logic                     underflow;
  logic [ADDRESS_WIDTH:0]   fifo_read_count;
  logic [ADDRESS_WIDTH:0]   rd_level;

  modport master (
    output write_enable, write_data, read_enable, aempty_value, underflow_clr,
    input  read_data, rdempty, wrfull, rd_almost_empty, underflow,
           fifo_read_count, rd_level
  );

  modport slave (
    input  write_enable, write_data, read_enable, aempty_value, underflow_clr,
    output read_data, rdempty, wrfull, rd_almost_empty, underflow,
           fifo_read_count, rd_level
  );
endinterface

// File: rtl/sync_fifo_rd_ctrl.sv
// Single-clock FIFO with read-side status (almost-empty, sticky underflow, read count, level).
// Define SYNC_FIFO_RD_FWFT_EN for first-word-fall-through read data; default is registered.
module sync_fifo_rd_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 4
) (
  input logic                rclk,
  input logic                hw_rst,
  sync_fifo_rd_ctrl_if.slave bus
);
  localparam int DEPTH = 1 << ADDRESS_WIDTH;
  localparam int PW    = ADDRESS_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [PW-1:0]         count_q, count_d;
  logic                  underflow_q, underflow_d;
  logic [PW-1:0]         level;
  logic                  empty, full, push_ok, pop_ok;

  always_comb begin
    level   = wptr_q - rptr_q;
    empty   = (level == '0);
    full    = (level == PW'(DEPTH));
    pop_ok  = bus.read_enable && !empty;
    // When full, a same-edge pop frees the slot the push lands in.
    push_ok = bus.write_enable && (!full || pop_ok);
    wptr_d  = wptr_q + {{ADDRESS_WIDTH{1'b0}}, push_ok};
    rptr_d  = rptr_q + {{ADDRESS_WIDTH{1'b0}}, pop_ok};
    count_d = count_q + {{ADDRESS_WIDTH{1'b0}}, pop_ok};
    underflow_d = underflow_q;
    if (bus.read_enable && empty) underflow_d = 1'b1;
    else if (bus.underflow_clr)   underflow_d = 1'b0;
  end

  always_ff @(posedge rclk) begin
    if (hw_rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge rclk) begin
    if (!hw_rst && push_ok) mem_q[wptr_q[ADDRESS_WIDTH-1:0]] <= bus.write_data;
  end

`ifdef SYNC_FIFO_RD_FWFT_EN
  assign bus.read_data = empty ? '0 : mem_q[rptr_q[ADDRESS_WIDTH-1:0]];
`else
  logic [DATA_WIDTH-1:0] read_data_q, read_data_d;

  always_comb begin
    read_data_d = read_data_q;
    if (pop_ok) read_data_d = mem_q[rptr_q[ADDRESS_WIDTH-1:0]];
  end

  always_ff @(posedge rclk) begin
    if (hw_rst) read_data_q <= '0;
    else        read_data_q <= read_data_d;
  end

  assign bus.read_data = read_data_q;
`endif

  assign bus.rdempty         = empty;
  assign bus.wrfull          = full;
  assign bus.rd_almost_empty = (level <= {1'b0, bus.aempty_value});
  assign bus.underflow       = underflow_q;
  assign bus.fifo_read_count = count_q;
  assign bus.rd_level        = level;
endmodule

// File: tb/tb_sync_fifo_rd_ctrl.sv
// Directed bench for sync_fifo_rd_ctrl: behavioural queue model drives expectations,
// a negedge monitor scores popped read data from exp_q.
module tb_sync_fifo_rd_ctrl;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic rclk = 1'b0;
  logic hw_rst;
  always #5 rclk = ~rclk;

  sync_fifo_rd_ctrl_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

  sync_fifo_rd_ctrl #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .rclk   (rclk),
    .hw_rst (hw_rst),
    .bus    (bus)
  );

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] model_q[$];
  int            model_cnt = 0;
  int            aev = 0;
  logic          model_uf = 1'b0;
  logic [DW-1:0] last_rd = '0;
  logic          exp_pop = 1'b0;
  logic          pop_d1 = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_status();
    int lvl;
    logic [DW-1:0] exp_rd;
    lvl = model_q.size();
`ifdef SYNC_FIFO_RD_FWFT_EN
    exp_rd = (lvl == 0) ? '0 : model_q[0];
`else
    exp_rd = last_rd;
`endif
    chk("rd_level",        32'(bus.rd_level),        32'(lvl));
    chk("rdempty",         32'(bus.rdempty),         32'(lvl == 0));
    chk("wrfull",          32'(bus.wrfull),          32'(lvl == DEPTH));
    chk("rd_almost_empty", 32'(bus.rd_almost_empty), 32'(lvl <= aev));
    chk("underflow",       32'(bus.underflow),       32'(model_uf));
    chk("fifo_read_count", 32'(bus.fifo_read_count), 32'(model_cnt));
    chk("read_data",       32'(bus.read_data),       32'(exp_rd));
  endtask

  // One clock: drive inputs, advance the model, then check status just after the edge.
  task automatic cycle(input logic we, input logic [DW-1:0] wd, input logic re,
                       input logic clr, input logic rst);
    int lvl;
    logic pop_ok, push_ok;
    lvl = model_q.size();
    hw_rst            = rst;
    bus.write_enable  = we;
    bus.write_data    = wd;
    bus.read_enable   = re;
    bus.underflow_clr = clr;
    bus.aempty_value  = AW'(aev);
    if (rst) begin
      model_q.delete();
      model_cnt = 0;
      model_uf  = 1'b0;
      last_rd   = '0;
      exp_pop   = 1'b0;
    end else begin
      pop_ok  = re && (lvl > 0);
      push_ok = we && ((lvl < DEPTH) || pop_ok);
      if (re && lvl == 0) model_uf = 1'b1;
      else if (clr)       model_uf = 1'b0;
      if (pop_ok) begin
        last_rd = model_q.pop_front();
        exp_q.push_back(last_rd);
        model_cnt = (model_cnt + 1) % 32;
      end
      if (push_ok) model_q.push_back(wd);
      exp_pop = pop_ok;
    end
    @(posedge rclk);
    #1;
    check_status();
  endtask

  always @(posedge rclk) pop_d1 <= exp_pop;

  // Monitor: registered mode shows the word the cycle after the pop, FWFT during it.
  initial begin
    logic [DW-1:0] e;
    logic          fire;
    forever begin
      @(negedge rclk);
`ifdef SYNC_FIFO_RD_FWFT_EN
      fire = exp_pop;
`else
      fire = pop_d1;
`endif
      if (fire) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_read_data: got %0h expected <none queued>", bus.read_data);
        end else begin
          e = exp_q.pop_front();
          if (bus.read_data !== e) begin
            n_fail++;
            $display("FAIL sb_read_data: got %0h expected %0h", bus.read_data, e);
          end
        end
      end
    end
  end

  initial begin
    // reset
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("reset_read_data", 32'(bus.read_data), 32'h0);
    chk("reset_rdempty",   32'(bus.rdempty),   32'h1);

    // fill to full, overflow push dropped, drain in order
    for (int i = 0; i < 16; i++) cycle(1'b1, DW'(8'h11 + i), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    chk("full_wrfull", 32'(bus.wrfull),   32'h1);
    chk("full_level",  32'(bus.rd_level), 32'd16);
    for (int i = 0; i < 16; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("drain_last_data", 32'(bus.read_data),       32'h20);
    chk("drain_count",     32'(bus.fifo_read_count), 32'd16);
    chk("drain_rdempty",   32'(bus.rdempty),         32'h1);

    // almost-empty threshold
    aev = 3;
    for (int i = 0; i < 4; i++) cycle(1'b1, DW'(8'h31 + i), 1'b0, 1'b0, 1'b0);
    chk("aempty_lvl4", 32'(bus.rd_almost_empty), 32'h0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("aempty_lvl3", 32'(bus.rd_almost_empty), 32'h1);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    aev = 0;
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("aempty_zero", 32'(bus.rd_almost_empty), 32'h1);

    // underflow set/clear/set-wins; push+pop while empty
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("uf_set",       32'(bus.underflow),       32'h1);
    chk("uf_count",     32'(bus.fifo_read_count), 32'd20);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("uf_clr",       32'(bus.underflow),       32'h0);
    cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
    chk("uf_set_wins",  32'(bus.underflow),       32'h1);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    chk("empty_pp_lvl", 32'(bus.rd_level),        32'd1);
    chk("empty_pp_uf",  32'(bus.underflow),       32'h1);
    cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);

    // full-rate streaming at full, count wrap
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) cycle(1'b1, DW'(8'h40 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) cycle(1'b1, DW'(8'h80 + i), 1'b1, 1'b0, 1'b0);
    chk("stream_count", 32'(bus.fifo_read_count), 32'd8);
    chk("stream_level", 32'(bus.rd_level),        32'd16);

    // reset wins over push+pop mid-operation
    for (int i = 0; i < 9; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_level", 32'(bus.rd_level), 32'd7);
    cycle(1'b1, 8'h55, 1'b1, 1'b0, 1'b1);
    chk("rst_level",   32'(bus.rd_level),        32'd0);
    chk("rst_rdempty", 32'(bus.rdempty),         32'h1);
    chk("rst_count",   32'(bus.fifo_read_count), 32'd0);

    // push into empty: FWFT shows it without read_enable
    cycle(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    chk("a5_rdempty", 32'(bus.rdempty), 32'h0);
`ifdef SYNC_FIFO_RD_FWFT_EN
    chk("a5_fwft_data", 32'(bus.read_data), 32'hA5);
`else
    chk("a5_reg_hold", 32'(bus.read_data), 32'h0);
`endif
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
